// File: rtl/fixed_math_pkg.sv
// Shared fixed-point math helpers for the squarer and the Newton square-root unit.
// Provides the FSM state type, a constant clog2, and the round/shift/saturate step.
package fixed_math_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  // Widest operand the shared saturation helper supports.
  localparam int MAXW = 64;

  function automatic int clog2(input int v);
    int r;
    if (v <= 1) return 1;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction

  // Returns {overflow, sq}; sq occupies the low `width` bits of the MAXW field.
  // The rounding add is done one bit wider than acc so its carry reaches the check.
  function automatic logic [MAXW:0] sat_shift(input logic [2*MAXW-1:0] acc,
                                              input logic             rnd,
                                              input int               width,
                                              input int               frac);
    logic [2*MAXW:0] sum;
    logic [2*MAXW:0] ones;
    logic [2*MAXW:0] one;
    one  = {{(2*MAXW){1'b0}}, 1'b1};
    sum  = {1'b0, acc};
    if (rnd && frac > 0) sum = sum + (one << (frac - 1));
    sum  = sum >> frac;
    ones = (one << width) - one;
    if ((sum & ~ones) != '0) return {1'b1, {MAXW{1'b1}}};
    return {1'b0, sum[MAXW-1:0]};
  endfunction

endpackage

// File: rtl/fixed_square_seq.sv
// Sequential unsigned fixed-point squarer, one multiplier bit per cycle (shift-add).
// Define SQUARE_ROUND_EN for round-half-up; otherwise the result is truncated.
module fixed_square_seq
  import fixed_math_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int FRACTIONAL_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sq,
  output logic             overflow
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
`ifdef SQUARE_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               done_q, ovf_q;
  logic [WIDTH-1:0]   sq_q;
  logic [2*MAXW-1:0]  acc_ext;
  logic [MAXW:0]      res;

  assign acc_ext = (2*MAXW)'(acc_q);
  assign res     = sat_shift(acc_ext, RND, WIDTH, FRACTIONAL_BITS);

  generate
    if (WIDTH < MAXW) begin : g_res_pad
      logic unused_res;
      assign unused_res = ^res[MAXW-1:WIDTH];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      sq_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          mcand_q  <= x;
          mplier_q <= x;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        CALC: begin
          if (mplier_q[cnt_q]) acc_q <= acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
          cnt_q <= cnt_q + CW'(1);
        end
        FINISH: begin
          sq_q   <= res[WIDTH-1:0];
          ovf_q  <= res[MAXW];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign sq       = sq_q;
  assign overflow = ovf_q;

endmodule
